// File: rtl/ps2_pkg.sv
// Shared PS/2 receive definitions.
//   ps2_state_e                 receiver FSM state encoding
//   PS2_FRAME_BITS              falling edges per frame (start + 8 data + parity + stop)
//   PS2_TIMEOUT_CYCLES_DEFAULT  default inter-edge timeout in CLOCK_50 cycles
//   ps2_parity_ok()             odd-parity check over {parity, data}
package ps2_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StRx      = 2'd1,
    StCheck   = 2'd2,
    StInhibit = 2'd3
  } ps2_state_e;

  localparam int unsigned PS2_FRAME_BITS             = 11;
  localparam int unsigned PS2_TIMEOUT_CYCLES_DEFAULT = 50000;

  // True when the number of ones across data and parity bit is odd.
  function automatic logic ps2_parity_ok(input logic [8:0] par_data);
    return ^par_data;
  endfunction

endpackage

// File: rtl/ps2_sync_fifo.sv
// Show-ahead synchronous FIFO for received PS/2 bytes.
//   CLOCK_50  system clock (rising edge)
//   reset     synchronous, active-high; empties the FIFO
//   push      write data when not full (or when full and a pop happens in the same cycle)
//   data_in   byte to write
//   pop       remove head entry; ignored while empty
//   data_out  head entry, 0 while empty
//   valid     FIFO not empty
//   full      occupancy equals DEPTH
//   count     current occupancy, 0..DEPTH
module ps2_sync_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     CLOCK_50,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         data_in,
  input  logic                     pop,
  output logic [WIDTH-1:0]         data_out,
  output logic                     valid,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             pop_ok;
  logic             push_ok;

  assign valid    = (count_q != '0);
  assign full     = (count_q == CW'(DEPTH));
  assign pop_ok   = pop & valid;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign push_ok  = push & (~full | pop_ok);
  assign data_out = valid ? mem_q[rd_ptr_q] : '0;
  assign count    = count_q;

  always_ff @(posedge CLOCK_50) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/ps2_rx_buffered.sv
// Receive-only PS/2 host interface with a byte FIFO.
//   CLOCK_50       system clock (rising edge)
//   reset          synchronous, active-high
//   PS2_CLK        open-drain PS/2 clock; pulled low only to inhibit the device while full
//   PS2_DAT        PS/2 data; never driven
//   rd_en          pop the head byte when rd_valid is set
//   rd_data        head byte (show-ahead), 0 while empty
//   rd_valid       FIFO not empty
//   fifo_count     FIFO occupancy
//   parity_error, framing_error, timeout_error, overflow   one-cycle event pulses
module ps2_rx_buffered
  import ps2_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH        = 8,
  parameter int unsigned TIMEOUT_CYCLES    = PS2_TIMEOUT_CYCLES_DEFAULT,
  parameter bit          INHIBIT_WHEN_FULL = 1'b1
) (
  input  logic                          CLOCK_50,
  input  logic                          reset,
  inout  wire                           PS2_CLK,
  inout  wire                           PS2_DAT,
  input  logic                          rd_en,
  output logic [7:0]                    rd_data,
  output logic                          rd_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          parity_error,
  output logic                          framing_error,
  output logic                          timeout_error,
  output logic                          overflow
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] FullCnt = CW'(FIFO_DEPTH);
  localparam logic [3:0]    LastBit = 4'(PS2_FRAME_BITS - 1);
  localparam logic [TW-1:0] ToLast  = TW'(TIMEOUT_CYCLES - 1);

  ps2_state_e    state_q;
  logic [1:0]    clk_sync_q;
  logic [1:0]    dat_sync_q;
  logic          clk_prev_q;
  logic [3:0]    bit_cnt_q;
  logic [TW-1:0] to_cnt_q;
  logic [9:0]    shift_q;
  logic          clk_low_q;
  logic          parity_error_q;
  logic          framing_error_q;
  logic          timeout_error_q;
  logic          overflow_q;

  logic          fall;
  logic          dat_s;
  logic          fifo_full;
  logic          will_pop;
  logic          frame_ok;
  logic          push;
  logic [CW-1:0] count_nxt;

  assign PS2_CLK = clk_low_q ? 1'b0 : 1'bz;
  assign PS2_DAT = 1'bz;

  assign parity_error  = parity_error_q;
  assign framing_error = framing_error_q;
  assign timeout_error = timeout_error_q;
  assign overflow      = overflow_q;

  // Synchronisers idle high so reset never looks like a falling edge.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
      clk_prev_q <= 1'b1;
    end else begin
      clk_sync_q <= {clk_sync_q[0], PS2_CLK};
      dat_sync_q <= {dat_sync_q[0], PS2_DAT};
      clk_prev_q <= clk_sync_q[1];
    end
  end

  assign fall  = clk_prev_q & ~clk_sync_q[1];
  assign dat_s = dat_sync_q[1];

  // shift_q holds {stop, parity, data[7:0]} once the 11th edge has been taken.
  assign will_pop  = rd_en & rd_valid;
  assign frame_ok  = shift_q[9] & ps2_parity_ok(shift_q[8:0]);
  assign push      = (state_q == StCheck) & frame_ok & (~fifo_full | will_pop);
  assign count_nxt = fifo_count + CW'(push) - CW'(will_pop);

  ps2_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .push     (push),
    .data_in  (shift_q[7:0]),
    .pop      (rd_en),
    .data_out (rd_data),
    .valid    (rd_valid),
    .full     (fifo_full),
    .count    (fifo_count)
  );

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q         <= StIdle;
      bit_cnt_q       <= '0;
      to_cnt_q        <= '0;
      shift_q         <= '0;
      clk_low_q       <= 1'b0;
      parity_error_q  <= 1'b0;
      framing_error_q <= 1'b0;
      timeout_error_q <= 1'b0;
      overflow_q      <= 1'b0;
    end else begin
      parity_error_q  <= 1'b0;
      framing_error_q <= 1'b0;
      timeout_error_q <= 1'b0;
      overflow_q      <= 1'b0;
      case (state_q)
        StIdle: begin
          bit_cnt_q <= '0;
          to_cnt_q  <= '0;
          if (INHIBIT_WHEN_FULL && count_nxt == FullCnt) begin
            state_q   <= StInhibit;
            clk_low_q <= 1'b1;
          end else if (fall && !dat_s) begin
            // Start bit is edge 1; an edge with data high is line noise.
            state_q   <= StRx;
            bit_cnt_q <= 4'd1;
          end
        end
        StRx: begin
          if (fall) begin
            shift_q  <= {dat_s, shift_q[9:1]};
            to_cnt_q <= '0;
            if (bit_cnt_q == LastBit) begin
              state_q <= StCheck;
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end else if (to_cnt_q == ToLast) begin
            timeout_error_q <= 1'b1;
            state_q         <= StIdle;
            bit_cnt_q       <= '0;
            to_cnt_q        <= '0;
          end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
          end
        end
        StCheck: begin
          bit_cnt_q <= '0;
          to_cnt_q  <= '0;
          if (!shift_q[9]) begin
            framing_error_q <= 1'b1;
          end else if (!ps2_parity_ok(shift_q[8:0])) begin
            parity_error_q <= 1'b1;
          end else if (!push) begin
            overflow_q <= 1'b1;
          end
          if (INHIBIT_WHEN_FULL && count_nxt == FullCnt) begin
            state_q   <= StInhibit;
            clk_low_q <= 1'b1;
          end else begin
            state_q <= StIdle;
          end
        end
        StInhibit: begin
          // Edges seen here are our own pull-down; ignore them.
          if (fifo_count != FullCnt) begin
            state_q   <= StIdle;
            clk_low_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= StIdle;
          clk_low_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/ps2_rx_buffered.md
PS2_RX_BUFFERED -- requirements
Module: ps2_rx_buffered

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, receive FIFO entries; power of two, at least 2.
REQ-002 Parameter TIMEOUT_CYCLES, default 50000, CLOCK_50 cycles allowed between PS2 clock falling edges within one frame.
REQ-003 Parameter INHIBIT_WHEN_FULL, default 1; 1 = hold PS2_CLK low while the FIFO is full.
REQ-004 CLOCK_50  in  1  system clock; all logic SHALL be on its rising edge.
REQ-005 reset  in  1  synchronous, active-high.
REQ-006 PS2_CLK  inout  1  PS2 clock, open-drain: driven 0 or high-Z only.
REQ-007 PS2_DAT  inout  1  PS2 data; SHALL always be high-Z (receive-only block).
REQ-008 rd_en  in  1  pops the head entry when rd_valid=1.
REQ-009 rd_data  out  8  FIFO head byte (show-ahead).
REQ-010 rd_valid  out  1  FIFO not empty.
REQ-011 fifo_count  out  clog2(FIFO_DEPTH)+1  current occupancy.
REQ-012 parity_error, framing_error, timeout_error, overflow  out  1 each  single-cycle event pulses.

Function
REQ-013 PS2_CLK and PS2_DAT SHALL pass through 2-flop synchronisers; a falling edge is synced-clock 1 to 0, and data SHALL be sampled on that edge.
REQ-014 Frame: start(0), 8 data bits LSB first, odd parity, stop(1); 11 falling edges.
REQ-015 States: IDLE, RX, CHECK, INHIBIT; any undefined encoding SHALL go to IDLE.
REQ-016 IDLE->RX on a falling edge with data 0; the start bit SHALL count as edge 1. A falling edge with data 1 SHALL be ignored.
REQ-017 RX->CHECK on the 11th edge; CHECK SHALL last exactly 1 cycle, then go to IDLE, or to INHIBIT per REQ-022.
REQ-018 CHECK order:
- stop!=1: framing_error.
- else parity wrong (ones in data plus parity bit not odd): parity_error.
- else FIFO full: overflow, byte dropped.
- else push.
- Only one pulse per frame.
REQ-019 Push in the CHECK cycle; rd_valid/fifo_count SHALL reflect it on the next cycle.
REQ-020 In RX, a cycle counter SHALL clear on each falling edge; on reaching TIMEOUT_CYCLES: timeout_error pulse, discard the partial frame, go to IDLE.
REQ-021 Pop on rd_en and rd_valid, 1 cycle; rd_en while empty SHALL be ignored. Same-cycle push and pop SHALL both take effect, including when full (count unchanged).
REQ-022 INHIBIT_WHEN_FULL=1:
- Enter INHIBIT from IDLE or CHECK when the FIFO is full after that cycle.
- In INHIBIT, drive PS2_CLK 0 and ignore edges.
- Release (high-Z) and go to IDLE on the cycle after fifo_count < FIFO_DEPTH.
- Never inhibit mid-frame.
REQ-023 INHIBIT_WHEN_FULL=0: INHIBIT SHALL be unreachable and PS2_CLK always high-Z.
REQ-024 Pointers SHALL wrap modulo FIFO_DEPTH; fifo_count SHALL never exceed FIFO_DEPTH.

Reset
REQ-025 Reset SHALL force:
- state IDLE; FIFO empty.
- rd_valid=0, fifo_count=0, rd_data=0x00.
- all pulses 0; PS2_CLK and PS2_DAT high-Z.
- synchronisers to 1; bit and timeout counters to 0.
REQ-026 Reset mid-frame SHALL discard the partial frame with no error pulse; the next complete frame SHALL be received normally.

Structure
REQ-027 Shared package ps2_pkg SHALL hold the state enum, PS2_FRAME_BITS=11 and the default TIMEOUT_CYCLES.
REQ-028 FIFO SHALL be sub-module ps2_sync_fifo (DEPTH, WIDTH=8, show-ahead, count output).

Verification (PS2 half-period 2500 cycles)
REQ-029 Frame 0x1C, parity 0 -> rd_valid=1, rd_data=0x1C, fifo_count=1, no error pulses; rd_en -> count 0.
REQ-030 Frame 0x1C, parity 1 -> one parity_error pulse, fifo_count=0; frame 0x1C, stop 0 -> one framing_error pulse.
REQ-031 Clock stops after 5 edges -> timeout_error exactly TIMEOUT_CYCLES after the last edge; then frame 0xF0 -> rd_data=0xF0.
REQ-032 FIFO_DEPTH=4, INHIBIT_WHEN_FULL=1:
- Frames 0x01..0x04 -> PS2_CLK low after the 4th CHECK.
- One rd_en -> PS2_CLK released within 2 cycles, count 3, rd_data=0x02.
REQ-033 FIFO_DEPTH=4, INHIBIT_WHEN_FULL=0:
- Frames 0x01..0x05 -> overflow on the 5th, count 4.
- Pops yield 0x01..0x04.
REQ-034 Reset after 6 edges of a frame -> all outputs at reset values; next frame 0x5A received correctly.
